csel_adder_pipe: RTL and testbench

- Parametrised, 2-stage pipelined carry-select adder/subtractor with valid/ready handshake on both sides.
- Successor to the 4-bit combinational CarrySelectAdder: generic width, add/subtract mode, signed-overflow flag, full-throughput streaming with backpressure.
- Sits between operand sources and ALU result consumers in the datapath library.

---
 rtl/csel_adder_pipe.sv | 140 ++++++++++++++
 tb/tb_csel_adder_pipe.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/csel_adder_pipe.sv
// Two-stage pipelined carry-select adder/subtractor with valid/ready on both sides.
// Stage 1 forms per-block sums for both carry-ins; stage 2 resolves the block carry chain.
module csel_adder_pipe #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int NBLK = WIDTH / BLOCK;
  localparam int HW   = (NBLK > 1) ? WIDTH - BLOCK : BLOCK;
  localparam int HN   = (NBLK > 1) ? NBLK - 1 : 1;

  logic [WIDTH-1:0] bx;
  logic             cx;
  logic             adv1, adv2;

  logic             s1_valid_d, s1_valid_q;
  logic [BLOCK-1:0] blk0_sum_d, blk0_sum_q;
  logic             blk0_c_d, blk0_c_q;
  logic [HW-1:0]    sum0_d, sum0_q, sum1_d, sum1_q;
  logic [HN-1:0]    c0_d, c0_q, c1_d, c1_q;
  logic             a_msb_d, a_msb_q, bx_msb_d, bx_msb_q;

  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q, ovf_d, ovf_q;
  logic [WIDTH-1:0] sel_sum;
  logic             carry;

  assign bx = Sub ? ~B : B;
  assign cx = Sub ? ~Cin : Cin;

  assign adv2     = s1_valid_q & (~out_valid_q | out_ready);
  assign in_ready = rst_n & (~s1_valid_q | adv2);
  assign adv1     = in_valid & in_ready;

  // Upper blocks are precomputed for both possible block carry-ins.
  always_comb begin
    s1_valid_d = s1_valid_q;
    blk0_sum_d = blk0_sum_q;
    blk0_c_d   = blk0_c_q;
    sum0_d     = sum0_q;
    sum1_d     = sum1_q;
    c0_d       = c0_q;
    c1_d       = c1_q;
    a_msb_d    = a_msb_q;
    bx_msb_d   = bx_msb_q;
    if (adv1) begin
      s1_valid_d = 1'b1;
      {blk0_c_d, blk0_sum_d} = {1'b0, A[BLOCK-1:0]} + {1'b0, bx[BLOCK-1:0]}
                               + {{BLOCK{1'b0}}, cx};
      for (int k = 1; k < NBLK; k++) begin
        {c0_d[k-1], sum0_d[(k-1)*BLOCK +: BLOCK]} =
          {1'b0, A[k*BLOCK +: BLOCK]} + {1'b0, bx[k*BLOCK +: BLOCK]};
        {c1_d[k-1], sum1_d[(k-1)*BLOCK +: BLOCK]} =
          {1'b0, A[k*BLOCK +: BLOCK]} + {1'b0, bx[k*BLOCK +: BLOCK]}
          + {{BLOCK{1'b0}}, 1'b1};
      end
      a_msb_d  = A[WIDTH-1];
      bx_msb_d = bx[WIDTH-1];
    end else if (adv2) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    carry                = blk0_c_q;
    sel_sum              = '0;
    sel_sum[BLOCK-1:0]   = blk0_sum_q;
    for (int k = 1; k < NBLK; k++) begin
      sel_sum[k*BLOCK +: BLOCK] = carry ? sum1_q[(k-1)*BLOCK +: BLOCK]
                                        : sum0_q[(k-1)*BLOCK +: BLOCK];
      carry = carry ? c1_q[k-1] : c0_q[k-1];
    end

    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    if (adv2) begin
      out_valid_d = 1'b1;
      sum_d       = sel_sum;
      cout_d      = carry;
      ovf_d       = (a_msb_q == bx_msb_q) & (sel_sum[WIDTH-1] != a_msb_q);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      blk0_sum_q  <= '0;
      blk0_c_q    <= 1'b0;
      sum0_q      <= '0;
      sum1_q      <= '0;
      c0_q        <= '0;
      c1_q        <= '0;
      a_msb_q     <= 1'b0;
      bx_msb_q    <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      blk0_sum_q  <= blk0_sum_d;
      blk0_c_q    <= blk0_c_d;
      sum0_q      <= sum0_d;
      sum1_q      <= sum1_d;
      c0_q        <= c0_d;
      c1_q        <= c1_d;
      a_msb_q     <= a_msb_d;
      bx_msb_q    <= bx_msb_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign Sum       = sum_q;
  assign Cout      = cout_q;
  assign Ovf       = ovf_q;

endmodule

// File: tb/tb_csel_adder_pipe.sv
// Bench for csel_adder_pipe at WIDTH=8, BLOCK=4: directed vectors, stall/reset sequences, random stream.
module tb_csel_adder_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready;
  logic [7:0] A, B;
  logic       Cin, Sub;
  logic       out_valid, out_ready;
  logic [7:0] Sum;
  logic       Cout, Ovf;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [9:0] exp_q[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vt[8];

  csel_adder_pipe #(.WIDTH(8), .BLOCK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin), .Sub(Sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .Sum(Sum), .Cout(Cout), .Ovf(Ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] ref_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic cin, input logic sub);
    logic [7:0] bxm;
    logic       cxm;
    logic [8:0] full;
    bxm  = sub ? ~b : b;
    cxm  = sub ? ~cin : cin;
    full = {1'b0, a} + {1'b0, bxm} + {8'b0, cxm};
    return {full[8], (a[7] == bxm[7]) && (full[7] != a[7]), full[7:0]};
  endfunction

  // rnd=0: beats A=i,B=0x0F add, out_ready low for cycles 4..6; rnd=1: random everything.
  task automatic run_stream(input int nbeats, input bit rnd);
    int         sent = 0;
    int         got  = 0;
    int         cyc  = 0;
    bit         prev_stall = 0;
    bit         last_fire  = 0;
    logic [7:0] prev_sum = '0;
    logic       fire_in, fire_out;
    logic [9:0] e;
    in_valid = 1'b0;
    while ((sent < nbeats || exp_q.size() > 0) && cyc < 20000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (last_fire) in_valid = 1'b0;
      if (!in_valid && sent < nbeats) begin
        if (rnd) begin
          A   = 8'($urandom_range(255));
          B   = 8'($urandom_range(255));
          Cin = 1'($urandom_range(1));
          Sub = 1'($urandom_range(1));
          in_valid = ($urandom_range(3) != 0);
        end else begin
          A   = 8'(sent);
          B   = 8'h0F;
          Cin = 1'b0;
          Sub = 1'b0;
          in_valid = 1'b1;
        end
      end
      out_ready = rnd ? 1'($urandom_range(1)) : !(cyc >= 4 && cyc <= 6);
      #1;
      if (prev_stall) begin
        chk("stall_hold_valid", out_valid, 1);
        chk("stall_hold_sum", Sum, prev_sum);
      end
      chk("in_ready", in_ready, !(out_ready == 1'b0 && exp_q.size() == 2));
      fire_in  = in_valid & in_ready;
      fire_out = out_valid & out_ready;
      if (fire_out) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", out_valid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("result", {Cout, Ovf, Sum}, e);
          got++;
        end
      end
      if (fire_in) begin
        exp_q.push_back(ref_model(A, B, Cin, Sub));
        sent++;
      end
      last_fire  = fire_in;
      prev_stall = out_valid & ~out_ready;
      prev_sum   = Sum;
    end
    chk("beats_out_eq_in", got, nbeats);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    vt[0] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
    vt[1] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
    vt[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vt[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
    vt[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    vt[5] = '{8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b1, 1'b0};
    vt[6] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
    vt[7] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; Cin = 1'b0; Sub = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", Sum, 0);
    chk("rst_cout", Cout, 0);
    chk("rst_ovf", Ovf, 0);
    chk("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    for (int i = 0; i < 8; i++) begin
      tick();
      A = vt[i].a; B = vt[i].b; Cin = vt[i].cin; Sub = vt[i].sub;
      in_valid = 1'b1;
      #1;
      chk("vec_in_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      chk("vec_lat1_valid", out_valid, 0);
      tick();
      chk("vec_lat2_valid", out_valid, 1);
      chk("vec_sum", Sum, vt[i].sum);
      chk("vec_cout", Cout, vt[i].cout);
      chk("vec_ovf", Ovf, vt[i].ovf);
      tick();
      chk("vec_valid_drop", out_valid, 0);
    end

    run_stream(6, 1'b0);

    // Fill both stages while stalled, then reset.
    tick();
    out_ready = 1'b0;
    A = 8'h80; B = 8'h01; Cin = 1'b0; Sub = 1'b1; in_valid = 1'b1;
    tick();
    A = 8'h03; B = 8'h04; Sub = 1'b0;
    #1;
    chk("fill_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("full_out_valid", out_valid, 1);
    chk("full_in_ready", in_ready, 0);
    chk("full_sum", Sum, 8'h7F);
    chk("full_cout", Cout, 1);
    chk("full_ovf", Ovf, 1);
    rst_n = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("in_ready_in_reset", in_ready, 0);
    tick();
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_sum", Sum, 0);
    chk("midrst_cout", Cout, 0);
    chk("midrst_ovf", Ovf, 0);
    rst_n = 1'b1;
    #1;
    chk("midrst_release_in_ready", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_stale_beat", out_valid, 0);
    end

    run_stream(1000, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
